// File: rtl/onewire_reset_master.sv
// onewire_reset_master: 1-Wire reset pulse generator with presence and stuck-bus detection
module onewire_reset_master #(
    parameter int T_RSTL   = 480,
    parameter int T_RSTH   = 480,
    parameter int T_SAMPLE = 70
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bus_in,
    output logic bus_drive_low,
    output logic busy,
    output logic done,
    output logic presence,
    output logic bus_error
);
    localparam int CW = $clog2((T_RSTL > T_RSTH ? T_RSTL : T_RSTH) + 1);
    localparam logic [CW-1:0] L_END = CW'(T_RSTL - 1);
    localparam logic [CW-1:0] H_END = CW'(T_RSTH - 1);
    localparam logic [CW-1:0] S_PT  = CW'(T_SAMPLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE_LOW, RECOVER, FINISH} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    sync;
    logic          bus_s;

    assign bus_s = sync[1];

    // two-flop synchronizer, preset high so an idle line reads released
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], bus_in};

    // state register; async reset drops the bus drive immediately
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // next-state logic; a low line at start skips straight to FINISH
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = bus_s ? DRIVE_LOW : FINISH;
            DRIVE_LOW: if (cnt == L_END) state_nx = RECOVER;
            RECOVER:   if (cnt == H_END) state_nx = FINISH;
            FINISH:    state_nx = IDLE;
        endcase
    end

    // outputs decoded from state only
    always_comb begin
        bus_drive_low = state == DRIVE_LOW;
        busy          = state == DRIVE_LOW || state == RECOVER;
        done          = state == FINISH;
    end

    // phase counter, cleared on every state entry and held at zero in IDLE
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= (state_nx != state || state == IDLE) ? '0 : cnt + 1'b1;

    // result flags: cleared on accept, presence sampled mid-recovery, stuck-low checked at its end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            presence  <= 1'b0;
            bus_error <= 1'b0;
        end else if (state == IDLE && start) begin
            presence  <= 1'b0;
            bus_error <= !bus_s;
        end else if (state == RECOVER) begin
            if (cnt == S_PT)  presence  <= !bus_s;
            if (cnt == H_END) bus_error <= !bus_s;
        end
endmodule

// File: tb/tb_onewire_reset_master.sv
// tb_onewire_reset_master: directed checks of reset timing, presence, stuck bus and abort
module tb_onewire_reset_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic slave_low = 1'b0;
    logic stuck = 1'b0;
    logic bus_in, bus_drive_low, busy, done, presence, bus_error;
    int   tests = 0;
    int   fails = 0;
    int   fd, nd, lc, bc;

    always #5 clk = ~clk;

    assign bus_in = !(bus_drive_low | slave_low | stuck);

    onewire_reset_master dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus_in(bus_in),
        .bus_drive_low(bus_drive_low), .busy(busy), .done(done),
        .presence(presence), .bus_error(bus_error)
    );

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // start at the current negedge, then watch n negedges; slave pulls low s_on..s_off cycles after release
    task automatic seq(input int s_on, input int s_off, input int p1, input int p2, input bit keep,
                       input int n, output int first_done, output int ndone, output int lowcnt,
                       output int busycnt);
        int rel;
        rel = -1; first_done = -1; ndone = 0; lowcnt = 0; busycnt = 0;
        start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (!keep) start = (k == p1 || k == p2);
            if (bus_drive_low) lowcnt++;
            else if (rel < 0 && lowcnt > 0) rel = k;
            if (rel >= 0 && k - rel == s_on) slave_low = 1'b1;
            if (rel >= 0 && k - rel == s_off) slave_low = 1'b0;
            if (busy) busycnt++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
        end
    endtask

    task automatic settle;
        slave_low = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_drive", bus_drive_low, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pres", presence, 0);
        chk("rst_err", bus_error, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        seq(20, 140, -1, -1, 0, 965, fd, nd, lc, bc);
        chk("pres_done_at", fd, 961);
        chk("pres_ndone", nd, 1);
        chk("pres_lowcnt", lc, 480);
        chk("pres_busycnt", bc, 960);
        chk("pres_presence", presence, 1);
        chk("pres_err", bus_error, 0);
        settle();

        seq(-1, -1, -1, -1, 0, 965, fd, nd, lc, bc);
        chk("none_done_at", fd, 961);
        chk("none_lowcnt", lc, 480);
        chk("none_presence", presence, 0);
        chk("none_err", bus_error, 0);
        settle();

        seq(20, 100000, -1, -1, 0, 965, fd, nd, lc, bc);
        chk("short_done_at", fd, 961);
        chk("short_presence", presence, 1);
        chk("short_err", bus_error, 1);
        settle();

        stuck = 1'b1;
        repeat (3) @(negedge clk);
        seq(-1, -1, -1, -1, 0, 4, fd, nd, lc, bc);
        chk("stuck_done_at", fd, 1);
        chk("stuck_ndone", nd, 1);
        chk("stuck_lowcnt", lc, 0);
        chk("stuck_busycnt", bc, 0);
        chk("stuck_presence", presence, 0);
        chk("stuck_err", bus_error, 1);
        chk("stuck_hold_err", bus_error, 1);
        stuck = 1'b0;
        settle();

        seq(-1, -1, 100, 500, 0, 1000, fd, nd, lc, bc);
        chk("ign_done_at", fd, 961);
        chk("ign_ndone", nd, 1);
        chk("ign_lowcnt", lc, 480);
        chk("ign_err", bus_error, 0);
        settle();

        seq(-1, -1, -1, -1, 1, 963, fd, nd, lc, bc);
        chk("hold_done_at", fd, 961);
        chk("hold_ndone", nd, 1);
        chk("hold_lowcnt", lc, 481);
        chk("hold_retrig", bus_drive_low, 1);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        settle();

        seq(-1, -1, -1, -1, 0, 200, fd, nd, lc, bc);
        chk("abort_pre_drive", bus_drive_low, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_drive", bus_drive_low, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pres", presence, 0);
        chk("abort_err", bus_error, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_nodone", done, 0);
        end
        rst_n = 1'b1;
        seq(-1, -1, -1, -1, 0, 962, fd, nd, lc, bc);
        chk("post_rst_done_at", fd, 961);
        chk("post_rst_lowcnt", lc, 480);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
